// File: rtl/register_file_pkg.sv
// Shared sizing constants and types for the integer register file, so the
// decode and writeback stages agree with the array on address and data widths.
package register_file_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DEPTH      = 2 ** RF_ADDR_WIDTH;

  typedef logic [RF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [RF_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/register_file_read_port.sv
// Combinational read mux selecting one entry of the register array.
// With REGFILE_ZERO_REG_EN defined, address 0 always reads as zero.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] entries [2**ADDR_WIDTH],
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  always_comb begin
`ifdef REGFILE_ZERO_REG_EN
    if (addr == '0) begin
      data = '0;
    end else begin
      data = entries[addr];
    end
`else
    data = entries[addr];
`endif
  end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write architectural register file with synchronous clear.
// Define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ra0,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic [DATA_WIDTH-1:0] out0,
  output logic [DATA_WIDTH-1:0] out1
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] entries [DEPTH];
  logic                  write_ok;

  always_comb begin
`ifdef REGFILE_ZERO_REG_EN
    write_ok = we && (wa != '0);
`else
    write_ok = we;
`endif
  end

  // Reset wins over a same-cycle write; reads are unbypassed, so a write is
  // only observable after the capturing edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (write_ok) begin
      entries[wa] <= wd;
    end
  end

  register_file_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_read_port0 (
    .entries(entries),
    .addr   (ra0),
    .data   (out0)
  );

  register_file_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_read_port1 (
    .entries(entries),
    .addr   (ra1),
    .data   (out1)
  );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected read values,
// a monitor on the falling edge pops and compares them against out0/out1.
module tb_register_file;

  logic        clock;
  logic        reset;
  logic [4:0]  ra0;
  logic [4:0]  ra1;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] out0;
  logic [31:0] out1;

  typedef struct {
    string       name;
    bit          port;
    logic [31:0] expected;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] zero_reg_expected;

  register_file dut (
    .clock(clock),
    .reset(reset),
    .ra0  (ra0),
    .ra1  (ra1),
    .we   (we),
    .wa   (wa),
    .wd   (wd),
    .out0 (out0),
    .out1 (out1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change just after a rising edge; the next rising edge commits them.
  task automatic applyStimulus(input logic rst_i, input logic we_i,
                               input logic [4:0] wa_i, input logic [31:0] wd_i,
                               input logic [4:0] ra0_i, input logic [4:0] ra1_i);
    @(posedge clock);
    #1;
    reset = rst_i;
    we    = we_i;
    wa    = wa_i;
    wd    = wd_i;
    ra0   = ra0_i;
    ra1   = ra1_i;
  endtask

  task automatic checkOutput(input string name, input bit port, input logic [31:0] expected);
    exp_t e;
    e.name     = name;
    e.port     = port;
    e.expected = expected;
    sb_q.push_back(e);
  endtask

  // Monitor: compares every queued expectation on the falling edge, midway
  // between the stimulus update and the next capturing edge.
  initial begin
    exp_t        e;
    logic [31:0] actual;
    forever begin
      @(negedge clock);
      while (sb_q.size() > 0) begin
        e      = sb_q.pop_front();
        actual = e.port ? out1 : out0;
        checks++;
        if (actual !== e.expected) begin
          failures++;
          $display("[TB] FAIL %s: out%0d got %h expected %h", e.name, e.port, actual, e.expected);
        end
      end
    end
  end

  initial begin
`ifdef REGFILE_ZERO_REG_EN
    zero_reg_expected = 32'h0000_0000;
`else
    zero_reg_expected = 32'hFFFF_FFFF;
`endif
    reset = 1'b1;
    we    = 1'b0;
    wa    = '0;
    wd    = '0;
    ra0   = '0;
    ra1   = '0;

    // Reset is captured on the first edge, then every address reads zero.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
      checkOutput("reset_sweep_out0", 1'b0, 32'd0);
      checkOutput("reset_sweep_out1", 1'b1, 32'd0);
    end

    applyStimulus(1'b0, 1'b1, 5'd25, 32'd10, 5'd25, 5'd0);
    checkOutput("write25_before_edge", 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd25, 5'd0);
    checkOutput("write25_after_edge", 1'b0, 32'd10);

    applyStimulus(1'b0, 1'b0, 5'd12, 32'd1024, 5'd0, 5'd12);
    applyStimulus(1'b0, 1'b0, 5'd12, 32'd1024, 5'd0, 5'd12);
    checkOutput("disabled_write12", 1'b1, 32'd0);
    applyStimulus(1'b0, 1'b1, 5'd12, 32'd1024, 5'd0, 5'd12);
    checkOutput("write12_before_edge", 1'b1, 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd12);
    checkOutput("write12_after_edge", 1'b1, 32'd1024);

    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd25, 5'd12);
    checkOutput("dual_read_out0", 1'b0, 32'd10);
    checkOutput("dual_read_out1", 1'b1, 32'd1024);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd25, 5'd25);
    checkOutput("same_addr_out0", 1'b0, 32'd10);
    checkOutput("same_addr_out1", 1'b1, 32'd10);

    applyStimulus(1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7);
    checkOutput("rdw_old_out0", 1'b0, 32'd0);
    checkOutput("rdw_old_out1", 1'b1, 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd25);
    checkOutput("rdw_new_out0", 1'b0, 32'hDEAD_BEEF);
    checkOutput("rdw_other_out1", 1'b1, 32'd10);

    // Reset held across two edges with writes pending on both.
    applyStimulus(1'b1, 1'b1, 5'd7, 32'd5, 5'd7, 5'd12);
    checkOutput("pre_reset_out0", 1'b0, 32'hDEAD_BEEF);
    checkOutput("pre_reset_out1", 1'b1, 32'd1024);
    applyStimulus(1'b1, 1'b1, 5'd25, 32'd99, 5'd7, 5'd25);
    checkOutput("reset_priority_out0", 1'b0, 32'd0);
    checkOutput("reset_cleared_out1", 1'b1, 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd25);
    checkOutput("reset_held_out0", 1'b0, 32'd0);
    checkOutput("reset_held_out1", 1'b1, 32'd0);

    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    checkOutput("zero_reg_before_edge", 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    checkOutput("zero_reg_neighbour", 1'b0, 32'd0);
    checkOutput("zero_reg_read", 1'b1, zero_reg_expected);

    // Drain the scoreboard, bounded so a stuck monitor cannot hang the run.
    for (int n = 0; n < 10 && sb_q.size() > 0; n++) begin
      @(posedge clock);
    end
    if (sb_q.size() > 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d pending expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
